// File: rtl/sdram_addr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_addr_pkg
//  Description : Shared SDRAM address geometry, linear->(BA,COL,ROW) slice
//                positions and the write-traversal FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_addr_pkg;

   localparam int BA_W   = 2;
   localparam int COL_W  = 9;
   localparam int ROW_W  = 13;
   localparam int ADDR_W = BA_W + COL_W + ROW_W;

   // Bit positions of each field inside the linear word count
   localparam int ROW_LSB = 0;
   localparam int COL_LSB = ROW_LSB + ROW_W;
   localparam int BA_LSB  = COL_LSB + COL_W;

   // Write traversal FSM
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } wr_state_t;

endpackage : sdram_addr_pkg
`default_nettype wire

// File: rtl/sdram_addr_map.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_addr_map
//  Description : Combinational split of the linear word count into SDRAM
//                bank / column / row. Shared by the read and write traversals
//                so both walk the array in the same order.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_addr_map
   import sdram_addr_pkg::*;
(
   input  logic [ADDR_W-1:0] i_count,
   output logic [BA_W-1:0]   o_ba,
   output logic [COL_W-1:0]  o_col,
   output logic [ROW_W-1:0]  o_row
);

   // Pure field extraction, row is the fastest-moving field
   always_comb begin
      o_ba  = i_count[BA_LSB  +: BA_W];
      o_col = i_count[COL_LSB +: COL_W];
      o_row = i_count[ROW_LSB +: ROW_W];
   end

endmodule : sdram_addr_map
`default_nettype wire

// File: rtl/write_address_traversal.sv
`default_nettype none
// ============================================================================
//  Module      : write_address_traversal
//  Description : Generates one SDRAM write address per captured word in the
//                reader's traversal order, tracks occupancy against reader
//                consumption and reports FULL/EMPTY, drops and laps.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_address_traversal
   import sdram_addr_pkg::*;
#(
   parameter int DROP_W       = 16,
   parameter int WRAP_W       = 8,
   parameter int AFULL_MARGIN = 1024
)
(
   input  logic              CLK_48MHZ,
   input  logic              RESET,
   input  logic              WRITE_REQ,
   input  logic              WRITE_DONE,
   input  logic              READ_NEXT,
   output logic [BA_W-1:0]   BA_WRITE_OUT,
   output logic [COL_W-1:0]  COL_WRITE_OUT,
   output logic [ROW_W-1:0]  ROW_WRITE_OUT,
   output logic              ADDR_VALID,
   output logic              FULL,
   output logic              ALMOST_FULL,
   output logic              EMPTY,
   output logic              UNDERRUN,
   output logic [ADDR_W:0]   FILL_COUNT,
   output logic [DROP_W-1:0] DROP_COUNT,
   output logic [WRAP_W-1:0] WRAP_COUNT
);

   localparam logic [ADDR_W:0] c_CAPACITY = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] c_MARGIN   = (ADDR_W+1)'(AFULL_MARGIN);

   wr_state_t           r_state;
   wr_state_t           w_state_nxt;
   logic                r_pending;
   logic                w_pending_nxt;
   logic [ADDR_W-1:0]   r_wr_count;
   logic [ADDR_W:0]     r_fill;
   logic                r_full;
   logic                r_afull;
   logic                r_empty;
   logic                r_underrun;
   logic [DROP_W-1:0]   r_drop;
   logic [WRAP_W-1:0]   r_wrap;

   logic                w_done_evt;
   logic                w_drop_inc;
   logic                w_addr_valid;
   logic                w_rd_dec;
   logic [ADDR_W:0]     w_fill_nxt;
   logic [ADDR_W:0]     w_free_nxt;

   // FSM state and single-deep pending-request register
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // Next-state, pending bookkeeping and drop detection
   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_drop_inc    = 1'b0;
      w_done_evt    = 1'b0;
      w_addr_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_full) begin
               // No room: never overwrite, new requests are lost
               if (WRITE_REQ) begin
                  w_drop_inc = 1'b1;
               end
            end else if (WRITE_REQ || r_pending) begin
               // Pending word goes first; a concurrent request takes its slot
               w_state_nxt   = ST_ISSUE;
               w_pending_nxt = r_pending & WRITE_REQ;
            end
         end
         ST_ISSUE: begin
            w_addr_valid = 1'b1;
            if (WRITE_REQ) begin
               if (r_pending) begin
                  w_drop_inc = 1'b1;
               end else begin
                  w_pending_nxt = 1'b1;
               end
            end
            if (WRITE_DONE) begin
               w_done_evt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Occupancy arithmetic; a read from an empty buffer is not counted
   always_comb begin
      w_rd_dec   = READ_NEXT && (r_fill != '0);
      w_fill_nxt = r_fill + {{ADDR_W{1'b0}}, w_done_evt}
                          - {{ADDR_W{1'b0}}, w_rd_dec};
      w_free_nxt = c_CAPACITY - w_fill_nxt;
   end

   // Write address counter and lap counter
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         r_wr_count <= '0;
         r_wrap     <= '0;
      end else if (w_done_evt) begin
         r_wr_count <= r_wr_count + 1'b1;
         if (r_wr_count == '1) begin
            r_wrap <= r_wrap + 1'b1;
         end
      end
   end

   // Fill level and its flags, all updated together from the next fill
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         r_fill  <= '0;
         r_full  <= 1'b0;
         r_afull <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_fill  <= w_fill_nxt;
         r_full  <= (w_fill_nxt == c_CAPACITY);
         r_afull <= (w_free_nxt <= c_MARGIN);
         r_empty <= (w_fill_nxt == '0);
      end
   end

   // Sticky underrun flag and saturating drop counter
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         r_underrun <= 1'b0;
         r_drop     <= '0;
      end else begin
         if (READ_NEXT && (r_fill == '0)) begin
            r_underrun <= 1'b1;
         end
         if (w_drop_inc && (r_drop != '1)) begin
            r_drop <= r_drop + 1'b1;
         end
      end
   end

   sdram_addr_map u_addr_map (
      .i_count (r_wr_count),
      .o_ba    (BA_WRITE_OUT),
      .o_col   (COL_WRITE_OUT),
      .o_row   (ROW_WRITE_OUT)
   );

   assign ADDR_VALID  = w_addr_valid;
   assign FULL        = r_full;
   assign ALMOST_FULL = r_afull;
   assign EMPTY       = r_empty;
   assign UNDERRUN    = r_underrun;
   assign FILL_COUNT  = r_fill;
   assign DROP_COUNT  = r_drop;
   assign WRAP_COUNT  = r_wrap;

endmodule : write_address_traversal
`default_nettype wire

// File: tb/tb_write_address_traversal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_address_traversal
//  Description : Directed self-checking bench for write_address_traversal.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_address_traversal;

   logic        clk;
   logic        rst;
   logic        req;
   logic        done;
   logic        rnext;
   logic [1:0]  ba;
   logic [8:0]  col;
   logic [12:0] row;
   logic        valid;
   logic        full;
   logic        afull;
   logic        empty;
   logic        underrun;
   logic [24:0] fill;
   logic [15:0] drop;
   logic [7:0]  wrap;

   int total;
   int bad;

   write_address_traversal #(
      .DROP_W       (16),
      .WRAP_W       (8),
      .AFULL_MARGIN (1024)
   ) dut (
      .CLK_48MHZ     (clk),
      .RESET         (rst),
      .WRITE_REQ     (req),
      .WRITE_DONE    (done),
      .READ_NEXT     (rnext),
      .BA_WRITE_OUT  (ba),
      .COL_WRITE_OUT (col),
      .ROW_WRITE_OUT (row),
      .ADDR_VALID    (valid),
      .FULL          (full),
      .ALMOST_FULL   (afull),
      .EMPTY         (empty),
      .UNDERRUN      (underrun),
      .FILL_COUNT    (fill),
      .DROP_COUNT    (drop),
      .WRAP_COUNT    (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Backdoor load of the fill level with its matching flags
   task automatic poke_fill(input logic [24:0] f, input logic fl, input logic af, input logic em);
      dut.r_fill  <= f;
      dut.r_full  <= fl;
      dut.r_afull <= af;
      dut.r_empty <= em;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req   = 1'b0;
      done  = 1'b0;
      rnext = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_afull", 32'(afull), 32'd0);
      chk("rst_fill", 32'(fill), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_under", 32'(underrun), 32'd0);

      // 1: single request, controller answers after three cycles
      req = 1'b1;
      tick();
      req = 1'b0;
      chk("t1_valid_c1", 32'(valid), 32'd1);
      chk("t1_addr_c1", {ba, col, row}, 32'd0);
      tick();
      chk("t1_valid_c2", 32'(valid), 32'd1);
      tick();
      chk("t1_valid_c3", 32'(valid), 32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t1_valid_end", 32'(valid), 32'd0);
      chk("t1_row", 32'(row), 32'd1);
      chk("t1_fill", 32'(fill), 32'd1);
      chk("t1_empty", 32'(empty), 32'd0);

      // 2: last address wraps to zero and bumps the lap count
      dut.r_wr_count <= 24'hFFFFFF;
      req = 1'b1;
      tick();
      req = 1'b0;
      chk("t2_valid", 32'(valid), 32'd1);
      chk("t2_ba_max", 32'(ba), 32'd3);
      chk("t2_col_max", 32'(col), 32'h1FF);
      chk("t2_row_max", 32'(row), 32'h1FFF);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t2_addr_zero", {ba, col, row}, 32'd0);
      chk("t2_wrap", 32'(wrap), 32'd1);
      chk("t2_fill", 32'(fill), 32'd2);

      // 3: request starts ISSUE, then three more while busy
      req = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      req = 1'b0;
      chk("t3_drop", 32'(drop), 32'd2);
      chk("t3_valid", 32'(valid), 32'd1);
      chk("t3_row0", 32'(row), 32'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t3_idle_gap", 32'(valid), 32'd0);
      chk("t3_fill3", 32'(fill), 32'd3);
      tick();
      chk("t3_reissue", 32'(valid), 32'd1);
      chk("t3_row1", 32'(row), 32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t3_row2", 32'(row), 32'd2);
      chk("t3_fill4", 32'(fill), 32'd4);

      // 4: one word short of capacity, write one to reach FULL
      poke_fill(25'h0FFFFFF, 1'b0, 1'b1, 1'b0);
      req = 1'b1;
      tick();
      req = 1'b0;
      chk("t4_valid", 32'(valid), 32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t4_full", 32'(full), 32'd1);
      chk("t4_fill_cap", 32'(fill), 32'h1000000);
      chk("t4_afull", 32'(afull), 32'd1);
      chk("t4_row3", 32'(row), 32'd3);
      req = 1'b1;
      tick();
      req = 1'b0;
      chk("t4_drop", 32'(drop), 32'd3);
      chk("t4_no_issue", 32'(valid), 32'd0);
      tick();
      chk("t4_still_idle", 32'(valid), 32'd0);
      rnext = 1'b1;
      tick();
      rnext = 1'b0;
      chk("t4_unfull", 32'(full), 32'd0);
      chk("t4_afull_keep", 32'(afull), 32'd1);
      chk("t4_fill_dec", 32'(fill), 32'hFFFFFF);

      // 4b: ALMOST_FULL edge at exactly AFULL_MARGIN free words
      poke_fill(25'h0FFFBFF, 1'b0, 1'b0, 1'b0);
      req = 1'b1;
      tick();
      req = 1'b0;
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t4b_afull_on", 32'(afull), 32'd1);
      chk("t4b_fill", 32'(fill), 32'hFFFC00);
      rnext = 1'b1;
      tick();
      rnext = 1'b0;
      chk("t4b_afull_off", 32'(afull), 32'd0);

      // 5: underrun at empty, then DONE and READ_NEXT together
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rnext = 1'b1;
      tick();
      rnext = 1'b0;
      chk("t5_fill0", 32'(fill), 32'd0);
      chk("t5_under", 32'(underrun), 32'd1);
      chk("t5_empty", 32'(empty), 32'd1);
      tick();
      chk("t5_under_sticky", 32'(underrun), 32'd1);
      poke_fill(25'd5, 1'b0, 1'b0, 1'b0);
      req = 1'b1;
      tick();
      req = 1'b0;
      done  = 1'b1;
      rnext = 1'b1;
      tick();
      done  = 1'b0;
      rnext = 1'b0;
      chk("t5_fill5", 32'(fill), 32'd5);
      chk("t5_row_adv", 32'(row), 32'd1);

      // 6: reset while ISSUE, then a stray DONE
      req = 1'b1;
      tick();
      req = 1'b0;
      chk("t6_valid", 32'(valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_valid_rst", 32'(valid), 32'd0);
      chk("t6_addr_rst", {ba, col, row}, 32'd0);
      chk("t6_fill_rst", 32'(fill), 32'd0);
      chk("t6_under_clr", 32'(underrun), 32'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t6_late_valid", 32'(valid), 32'd0);
      chk("t6_late_addr", {ba, col, row}, 32'd0);
      chk("t6_late_fill", 32'(fill), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_write_address_traversal
`default_nettype wire
